tx_symbol_scheduler: RTL

- Sequencer that drives the transmitter's `control_dk` symbol-select input, one symbol per clock.
- Generates the following symbol streams:
  - FTS ordered sets after enable.
  - Periodic SKP ordered sets.
  - STP/SDP-framed packets terminated by END, or by EDB on abort.
  - IDLE fill when there is nothing else to send.
- Sits between the link-layer packet source and the transmitter (mux + byte striping to 4 lanes). It decides what the transmitter emits each cycle and strobes the packet-data source.

---
 rtl/tx_sym_pkg.sv | 40 ++++
 rtl/tx_symbol_scheduler_os_gen.sv | 55 +++++
 rtl/tx_symbol_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_sym_pkg.sv
// Shared symbol codes, scheduler state encoding and ordered-set defaults for
// the transmit path (scheduler and transmitter mux decode).
package tx_sym_pkg;

    typedef logic [3:0] sym_t;

    // control_dk symbol-select codes
    localparam sym_t SYM_DATA = 4'b0000;
    localparam sym_t SYM_COM  = 4'b0001;
    localparam sym_t SYM_SKP  = 4'b0010;
    localparam sym_t SYM_STP  = 4'b0011;
    localparam sym_t SYM_SDP  = 4'b0100;
    localparam sym_t SYM_END  = 4'b0101;
    localparam sym_t SYM_EDB  = 4'b0110;
    localparam sym_t SYM_FTS  = 4'b0111;
    localparam sym_t SYM_IDLE = 4'b1000;

    // scheduler state encoding
    localparam logic [3:0] ST_DISABLED = 4'd0;
    localparam logic [3:0] ST_FTS_COM  = 4'd1;
    localparam logic [3:0] ST_FTS_BODY = 4'd2;
    localparam logic [3:0] ST_IDLE     = 4'd3;
    localparam logic [3:0] ST_SKP_COM  = 4'd4;
    localparam logic [3:0] ST_SKP_BODY = 4'd5;
    localparam logic [3:0] ST_HDR      = 4'd6;
    localparam logic [3:0] ST_DATA     = 4'd7;
    localparam logic [3:0] ST_END      = 4'd8;

    localparam int DEF_LANES        = 4;
    localparam int DEF_OS_SYMS      = 3;
    localparam int DEF_N_FTS        = 2;
    localparam int DEF_SKP_INTERVAL = 1180;
    localparam int DEF_LEN_W        = 8;

    // total symbols in one ordered set: COM run plus body run
    function automatic int os_len(input int lanes, input int os_syms);
        return lanes * (1 + os_syms);
    endfunction

endpackage

// File: rtl/tx_symbol_scheduler_os_gen.sv
// Ordered-set sequencer: counts a COM run of LANES symbols followed by a body
// run of LANES*OS_SYMS symbols of body_code, and looks one symbol ahead so the
// caller can register its output.
module os_gen
    import tx_sym_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int OS_SYMS = DEF_OS_SYMS
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  sym_t body_code,
    output logic com_last,
    output logic done,
    output sym_t nxt_sym
);

    localparam int OS_LEN = os_len(LANES, OS_SYMS);
    localparam int CNT_W  = $clog2(OS_LEN);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(OS_LEN - 1);
    localparam logic [CNT_W-1:0] BODY_LEN = CNT_W'(LANES * OS_SYMS);

    logic             active;
    logic [CNT_W-1:0] cnt;

    // Down-count the symbols left in the current ordered set; start reloads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CNT_TOP;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign com_last = active && (cnt == BODY_LEN);
    assign done     = active && (cnt == '0);

    // Symbol for the next cycle: COM while the COM run continues, else body.
    always_comb begin
        nxt_sym = body_code;
        if (start || (active && (cnt > BODY_LEN))) begin
            nxt_sym = SYM_COM;
        end
    end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler: FTS training after enable, periodic SKP
// insertion, STP/SDP-framed packets closed by END (or EDB on abort), IDLE fill.
//
// state       | meaning
// ------------+-----------------------------------------------
// DISABLED    | link off, IDLE out, SKP timer held at 0
// FTS_COM     | COM run of an FTS ordered set
// FTS_BODY    | FTS body run; repeats N_FTS sets
// IDLE        | IDLE out, arbitrate SKP > packet > disable
// SKP_COM     | COM run of a SKP ordered set
// SKP_BODY    | SKP body run
// HDR         | STP/SDP out with pkt_ack, length latched
// DATA        | data symbols, data_rd high
// END         | END, or EDB when the packet was aborted
module tx_symbol_scheduler
    import tx_sym_pkg::*;
#(
    parameter int LANES        = DEF_LANES,
    parameter int OS_SYMS      = DEF_OS_SYMS,
    parameter int N_FTS        = DEF_N_FTS,
    parameter int SKP_INTERVAL = DEF_SKP_INTERVAL,
    parameter int LEN_W        = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             pkt_req,
    input  logic             pkt_type,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             pkt_abort,
    output logic [3:0]       control_dk,
    output logic             pkt_ack,
    output logic             data_rd,
    output logic             busy,
    output logic             skp_pending
);

    localparam int TMR_W = $clog2(SKP_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SKP_INTERVAL - 1);
    localparam int FTS_W = (N_FTS > 1) ? $clog2(N_FTS) : 1;
    localparam logic [FTS_W-1:0] FTS_LAST = FTS_W'(N_FTS - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [3:0]       state;
    logic [3:0]       nxt_state;
    logic             os_start;
    logic             os_com_last;
    logic             os_done;
    sym_t             os_body;
    sym_t             os_nxt_sym;
    sym_t             nxt_sym;
    logic [TMR_W-1:0] skp_tmr;
    logic [FTS_W-1:0] fts_cnt;
    logic [LEN_W-1:0] len_cnt;
    logic             in_fts;
    logic             tmr_run;
    logic             tmr_expire;

    assign in_fts     = (state == ST_FTS_COM) || (state == ST_FTS_BODY);
    assign tmr_run    = (state != ST_DISABLED) && !in_fts;
    assign tmr_expire = tmr_run && (skp_tmr == TMR_LAST);
    // Only DISABLED and the FTS states ever launch an FTS set.
    assign os_body    = ((state == ST_DISABLED) || in_fts) ? SYM_FTS : SYM_SKP;

    os_gen #(
        .LANES   (LANES),
        .OS_SYMS (OS_SYMS)
    ) u_os_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (os_start),
        .body_code (os_body),
        .com_last  (os_com_last),
        .done      (os_done),
        .nxt_sym   (os_nxt_sym)
    );

    // Next-state decision and ordered-set launch.
    always_comb begin
        nxt_state = state;
        os_start  = 1'b0;
        case (state)
            ST_DISABLED: begin
                if (enb) begin
                    nxt_state = ST_FTS_COM;
                    os_start  = 1'b1;
                end
            end
            ST_FTS_COM: begin
                if (os_com_last) nxt_state = ST_FTS_BODY;
            end
            ST_FTS_BODY: begin
                if (os_done) begin
                    if (fts_cnt == FTS_LAST) begin
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_state = ST_FTS_COM;
                        os_start  = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (skp_pending) begin
                    nxt_state = ST_SKP_COM;
                    os_start  = 1'b1;
                end else if (pkt_req) begin
                    nxt_state = ST_HDR;
                end else if (!enb) begin
                    nxt_state = ST_DISABLED;
                end
            end
            ST_SKP_COM: begin
                if (os_com_last) nxt_state = ST_SKP_BODY;
            end
            ST_SKP_BODY: begin
                if (os_done) nxt_state = ST_IDLE;
            end
            ST_HDR: begin
                nxt_state = (len_cnt == '0) ? ST_END : ST_DATA;
            end
            ST_DATA: begin
                if (pkt_abort || (len_cnt == LEN_ONE)) nxt_state = ST_END;
            end
            ST_END: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_DISABLED;
            end
        endcase
    end

    // Symbol that the decision above puts on the wire next cycle.
    always_comb begin
        nxt_sym = SYM_IDLE;
        case (nxt_state)
            ST_FTS_COM, ST_FTS_BODY,
            ST_SKP_COM, ST_SKP_BODY: nxt_sym = os_nxt_sym;
            ST_HDR:                  nxt_sym = pkt_type ? SYM_SDP : SYM_STP;
            ST_DATA:                 nxt_sym = SYM_DATA;
            ST_END:                  nxt_sym = (state == ST_DATA && pkt_abort) ? SYM_EDB : SYM_END;
            default:                 nxt_sym = SYM_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_DISABLED;
            control_dk <= SYM_IDLE;
            pkt_ack    <= 1'b0;
            data_rd    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            control_dk <= nxt_sym;
            pkt_ack    <= (nxt_state == ST_HDR);
            data_rd    <= (nxt_state == ST_DATA);
            busy       <= !((nxt_state == ST_IDLE) || (nxt_state == ST_DISABLED));
        end
    end

    // FTS set counter and packet length latch/count-down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fts_cnt <= '0;
            len_cnt <= '0;
        end else begin
            if (state == ST_DISABLED) begin
                fts_cnt <= '0;
            end else if (state == ST_FTS_BODY && os_done) begin
                fts_cnt <= fts_cnt + 1'b1;
            end
            if (state == ST_IDLE && nxt_state == ST_HDR) begin
                len_cnt <= pkt_len;
            end else if (state == ST_DATA) begin
                len_cnt <= len_cnt - 1'b1;
            end
        end
    end

    // SKP interval timer; an expiry while a SKP is already owed is absorbed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skp_tmr     <= '0;
            skp_pending <= 1'b0;
        end else begin
            if (state == ST_DISABLED) begin
                skp_tmr <= '0;
            end else if (tmr_run) begin
                skp_tmr <= tmr_expire ? '0 : skp_tmr + 1'b1;
            end
            if (state == ST_IDLE && skp_pending) begin
                skp_pending <= 1'b0;
            end else if (tmr_expire) begin
                skp_pending <= 1'b1;
            end
        end
    end

endmodule
